// File: rtl/perf_monitor.sv
// perf_monitor -- pipeline performance counter block.
//
// Counts RUN cycles, qualified IF/ID stalls and IF/ID flushes while the CPU
// start level is high. The live counters can be copied to snapshot outputs
// on request.
//
// Parameters
//   CNT_W        width of each counter and snapshot output
//   CYCLE_LIMIT  RUN cycles after which counting stops (DONE); 0 = unlimited.
//                Assumed to fit in CNT_W bits.
//
// Configuration macro
//   PERF_MON_SATURATE_EN  defined:   counters saturate at all-ones and hold
//                         undefined: counters wrap to zero
//   In both modes, ovf_o is set on the edge where the first overflowing
//   increment is applied or blocked.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-low reset
//   start_i       count enable level (high = count, low = pause)
//   stall_i       IF/ID stall, counted only when branch_i is low
//   branch_i      branch indication that masks stall_i
//   flush_i       IF/ID flush
//   clear_i       one-cycle request: zero counters and ovf, return to IDLE
//   snap_i        one-cycle request: copy live counters to snapshot outputs
//   snap_cycle_o  snapshot of cycle counter
//   snap_stall_o  snapshot of stall counter
//   snap_flush_o  snapshot of flush counter
//   snap_valid_o  high for the cycle after each edge that sampled snap_i
//   busy_o        state is RUN
//   done_o        state is DONE
//   ovf_o         sticky overflow flag
//
// Handshake: there is no back-pressure. snap_valid_o is a pure status pulse.
// Every edge that samples snap_i=1 reloads the snapshot registers and drives
// snap_valid_o high for the following cycle. Held requests therefore give
// one reload and one valid cycle per edge.
//
// busy_o and done_o together expose the FSM state
// (IDLE = 00, RUN = 10, DONE = 01).

module perf_monitor #(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             flush_i,
    input  logic             clear_i,
    input  logic             snap_i,
    output logic [CNT_W-1:0] snap_cycle_o,
    output logic [CNT_W-1:0] snap_stall_o,
    output logic [CNT_W-1:0] snap_flush_o,
    output logic             snap_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CYCLE_LIMIT);
    localparam bit               LIMIT_EN = (CYCLE_LIMIT != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] snap_cycle_q, snap_stall_q, snap_flush_q;
    logic             snap_valid_q;

    // Incremented values, MSB = overflow of this increment.
    logic [CNT_W:0]   cyc_res, stl_res, fls_res;
    logic             count_en;
    logic             stall_ev;

    // Returns {overflow, next value} for one increment of v.
    function automatic logic [CNT_W:0] incr(input logic [CNT_W-1:0] v);
`ifdef PERF_MON_SATURATE_EN
        if (&v) begin
            incr = {1'b1, v};
        end else begin
            incr = {1'b0, v + CNT_W'(1)};
        end
`else
        incr = {&v, v + CNT_W'(1)};
`endif
    endfunction

    always_comb begin
        cyc_res  = incr(cycle_q);
        stl_res  = incr(stall_q);
        fls_res  = incr(flush_q);
        // Only a RUN edge with start still high counts; the pause edge
        // (RUN->IDLE) and the entry edge (IDLE->RUN) do not.
        count_en = (state_q == RUN) && start_i;
        stall_ev = stall_i && !branch_i;

        state_d  = state_q;
        cycle_d  = cycle_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else if (LIMIT_EN && (cyc_res[CNT_W-1:0] == LIMIT)) begin
                    // Limit reached on this counting edge wins over staying in RUN.
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (count_en) begin
            cycle_d = cyc_res[CNT_W-1:0];
            ovf_d   = ovf_d | cyc_res[CNT_W];
            if (stall_ev) begin
                stall_d = stl_res[CNT_W-1:0];
                ovf_d   = ovf_d | stl_res[CNT_W];
            end
            if (flush_i) begin
                flush_d = fls_res[CNT_W-1:0];
                ovf_d   = ovf_d | fls_res[CNT_W];
            end
        end

        // Clear overrides every transition and increment above.
        if (clear_i) begin
            state_d = IDLE;
            cycle_d = '0;
            stall_d = '0;
            flush_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
        end
    end

    // Snapshot captures the pre-edge live values, so a snap together with a
    // clear still records the counts being cleared.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            snap_cycle_q <= '0;
            snap_stall_q <= '0;
            snap_flush_q <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap_i;
            if (snap_i) begin
                snap_cycle_q <= cycle_q;
                snap_stall_q <= stall_q;
                snap_flush_q <= flush_q;
            end
        end
    end

    assign snap_cycle_o = snap_cycle_q;
    assign snap_stall_o = snap_stall_q;
    assign snap_flush_o = snap_flush_q;
    assign snap_valid_o = snap_valid_q;
    assign busy_o       = (state_q == RUN);
    assign done_o       = (state_q == DONE);
    assign ovf_o        = ovf_q;

endmodule
